// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types, default timing and width helpers for the key conditioner
package key_pkg;

  // Auto-repeat state per key
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_e;

  // Default timing at 50 MHz
  localparam int DEB_10MS         = 500000;
  localparam int REP_DELAY_500MS  = 25000000;
  localparam int REP_PERIOD_100MS = 5000000;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one pushbutton: synchronizer, debouncer, edge pulses, auto-repeat
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_10MS,
  parameter int REPEAT_DELAY    = REP_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REP_PERIOD_100MS,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_event_nxt
);

  localparam int DCW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RCW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  logic             r_meta;
  logic             r_sync;
  logic             r_st;
  logic [DCW-1:0]   r_dc;
  logic             r_press;
  logic             r_release;
  logic             r_repeat;
  logic [RCW-1:0]   r_rc;
  key_state_e       r_state;

  logic w_s;
  logic w_accept;
  logic w_st_nxt;
  logic w_press_nxt;
  logic w_rel_nxt;
  logic w_rep_nxt;

  // Pin is active-low; inverted sample reads 1 while pressed
  assign w_s         = ~r_sync;
  assign w_accept    = (w_s != r_st) && (r_dc == DCW'(DEBOUNCE_CYCLES - 1));
  assign w_st_nxt    = w_accept ? w_s : r_st;
  assign w_press_nxt = w_accept && w_s;
  assign w_rel_nxt   = w_accept && !w_s;

  // Repeat terminal count is suppressed when the key is released in the same cycle
  assign w_rep_nxt = w_st_nxt &&
                     (((r_state == ST_DELAY) && REPEAT_EN &&
                       (r_rc == RCW'(REPEAT_DELAY - 1))) ||
                      ((r_state == ST_REPEAT) &&
                       (r_rc == RCW'(REPEAT_PERIOD - 1))));

  assign o_event_nxt = w_press_nxt || w_rep_nxt;

  // Two-flop synchronizer, resets to the released level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_key;
      r_sync <= r_meta;
    end
  end

  // Debouncer: a new level must hold DEBOUNCE_CYCLES consecutive samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st      <= 1'b0;
      r_dc      <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_press_nxt;
      r_release <= w_rel_nxt;
      if (w_s == r_st) begin
        r_dc <= '0;
      end else if (w_accept) begin
        r_st <= w_s;
        r_dc <= '0;
      end else begin
        r_dc <= r_dc + 1'b1;
      end
    end
  end

  // Auto-repeat FSM, entered in the same cycle the press is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_rc     <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= w_rep_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_press_nxt) begin
            r_state <= ST_DELAY;
            r_rc    <= '0;
          end
        end
        ST_DELAY: begin
          if (!w_st_nxt) begin
            r_state <= ST_IDLE;
            r_rc    <= '0;
          end else if (w_rep_nxt) begin
            r_state <= ST_REPEAT;
            r_rc    <= '0;
          end else if (REPEAT_EN) begin
            r_rc <= r_rc + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!w_st_nxt) begin
            r_state <= ST_IDLE;
            r_rc    <= '0;
          end else if (w_rep_nxt) begin
            r_rc <= '0;
          end else begin
            r_rc <= r_rc + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rc    <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_st;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced, edge-detected, auto-repeating pushbutton bank
module key_conditioner
  import key_pkg::*;
#(
  parameter int               NKEYS           = 4,
  parameter int               DEBOUNCE_CYCLES = DEB_10MS,
  parameter int               REPEAT_DELAY    = REP_DELAY_500MS,
  parameter int               REPEAT_PERIOD   = REP_PERIOD_100MS,
  parameter logic [NKEYS-1:0] REPEAT_MASK     = 4'b0011
) (
  input  logic             iCLK_50,
  input  logic             iRST_N,
  input  logic [NKEYS-1:0] iKEY,
  output logic [NKEYS-1:0] oKEY_LEVEL,
  output logic [NKEYS-1:0] oKEY_PRESS,
  output logic [NKEYS-1:0] oKEY_RELEASE,
  output logic [NKEYS-1:0] oKEY_REPEAT,
  output logic             oKEY_EVENT
);

  logic [NKEYS-1:0] w_event_nxt;
  logic             r_event;

  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[gi])
    ) u_channel (
      .i_clk       (iCLK_50),
      .i_rst_n     (iRST_N),
      .i_key       (iKEY[gi]),
      .o_level     (oKEY_LEVEL[gi]),
      .o_press     (oKEY_PRESS[gi]),
      .o_release   (oKEY_RELEASE[gi]),
      .o_repeat    (oKEY_REPEAT[gi]),
      .o_event_nxt (w_event_nxt[gi])
    );
  end

  // Event register built from next-cycle pulses so it lines up with them
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_event <= 1'b0;
    end else begin
      r_event <= |w_event_nxt;
    end
  end

  assign oKEY_EVENT = r_event;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] level, press, release_p, repeat_p;
  logic       event_p;

  int checks   = 0;
  int failures = 0;

  key_conditioner #(
    .NKEYS           (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .REPEAT_MASK     (4'b0011)
  ) dut (
    .iCLK_50      (clk),
    .iRST_N       (rst_n),
    .iKEY         (key),
    .oKEY_LEVEL   (level),
    .oKEY_PRESS   (press),
    .oKEY_RELEASE (release_p),
    .oKEY_REPEAT  (repeat_p),
    .oKEY_EVENT   (event_p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] el, input logic [3:0] ep,
                     input logic [3:0] er, input logic [3:0] et, input logic ee);
    checks++;
    assert (level === el) else begin
      failures++;
      $error("FAIL %s level observed=%h expected=%h", tag, level, el);
    end
    checks++;
    assert (press === ep) else begin
      failures++;
      $error("FAIL %s press observed=%h expected=%h", tag, press, ep);
    end
    checks++;
    assert (release_p === er) else begin
      failures++;
      $error("FAIL %s release observed=%h expected=%h", tag, release_p, er);
    end
    checks++;
    assert (repeat_p === et) else begin
      failures++;
      $error("FAIL %s repeat observed=%h expected=%h", tag, repeat_p, et);
    end
    checks++;
    assert (event_p === ee) else begin
      failures++;
      $error("FAIL %s event observed=%h expected=%h", tag, event_p, ee);
    end
  endtask

  initial begin
    logic [15:0] bounce;
    logic        rp;

    // 1. Reset with all keys held, then release reset
    rst_n = 1'b0;
    key   = 4'b0000;
    tick();
    tick();
    chk("t1_in_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e <= 16; e++) begin
      if (e == 8) key = 4'hF;
      tick();
      chk($sformatf("t1_e%0d", e),
          (e >= 5 && e < 13) ? 4'hF : 4'h0,
          (e == 5) ? 4'hF : 4'h0,
          (e == 13) ? 4'hF : 4'h0,
          4'h0,
          e == 5);
    end

    // 2 and 4. Key 0 press, auto-repeat, release before edge 20
    @(negedge clk);
    key = 4'b1110;
    for (int e = 0; e <= 32; e++) begin
      if (e == 20) key = 4'hF;
      tick();
      rp = (e >= 15 && e <= 24 && ((e - 15) % 3 == 0));
      chk($sformatf("t2_e%0d", e),
          {3'b000, (e >= 5 && e < 25)},
          {3'b000, (e == 5)},
          {3'b000, (e == 25)},
          {3'b000, rp},
          (e == 5) || rp);
    end

    // 3. Bounce on key 1 never reaches acceptance
    bounce = 16'b1111_1111_1000_1000;
    @(negedge clk);
    for (int e = 0; e < 16; e++) begin
      key = {2'b11, bounce[e], 1'b1};
      tick();
      chk($sformatf("t3_e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    end

    // 5. Masked key 2 held for 40 cycles
    @(negedge clk);
    key = 4'b1011;
    for (int e = 0; e <= 50; e++) begin
      if (e == 40) key = 4'hF;
      tick();
      chk($sformatf("t5_e%0d", e),
          (e >= 5 && e < 45) ? 4'b0100 : 4'h0,
          (e == 5) ? 4'b0100 : 4'h0,
          (e == 45) ? 4'b0100 : 4'h0,
          4'h0,
          e == 5);
    end

    // 6. Reset asserted between edges while key 0 repeats
    @(negedge clk);
    key = 4'b1110;
    for (int e = 0; e <= 16; e++) begin
      tick();
      chk($sformatf("t6a_e%0d", e),
          {3'b000, (e >= 5)}, {3'b000, (e == 5)}, 4'h0,
          {3'b000, (e == 15)}, (e == 5) || (e == 15));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick();
    tick();
    chk("t6_held_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      rp = (e == 15) || (e == 18);
      chk($sformatf("t6b_e%0d", e),
          {3'b000, (e >= 5)}, {3'b000, (e == 5)}, 4'h0,
          {3'b000, rp}, (e == 5) || rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
